bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared data bus. The winner drives data/DE/DRW for
// HOLD_CYCLES cycles, gets a one-cycle ack with the final bus cycle, then the bus idles for one cycle.
module bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_rw,
  input  logic [DATA_W-1:0]         bus_rdata,
  output logic [DATA_W-1:0]         data,
  output logic                      DE,
  output logic                      DRW,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rdata
);

  localparam int         IDX_W     = $clog2(N_REQ);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                de_q, de_d;
  logic                drw_q, drw_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                found_s;
  logic [2*N_REQ-1:0]  dbl_s;
  logic [N_REQ-1:0]    rot_s;
  logic [IDX_W-1:0]    off_s;
  logic [IDX_W:0]      sum_s;
  logic [IDX_W-1:0]    win_s;

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_REQ-1)) ? {IDX_W{1'b0}} : idx + {{(IDX_W-1){1'b0}}, 1'b1};
  endfunction

  // Rotate req so bit 0 is the requester at ptr; the lowest set bit is the winner.
  always_comb begin
    found_s = |req;
    dbl_s   = {req, req} >> ptr_q;
    rot_s   = dbl_s[N_REQ-1:0];
    off_s   = {IDX_W{1'b0}};
    for (int i = N_REQ-1; i >= 0; i--) begin
      off_s = rot_s[i] ? IDX_W'(i) : off_s;
    end
    sum_s = {1'b0, ptr_q} + {1'b0, off_s};
    win_s = (sum_s >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum_s - (IDX_W+1)'(N_REQ)) : sum_s[IDX_W-1:0];
  end

  // Next-state and registered-output logic for the IDLE/GRANT/RELEASE controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    de_d    = de_q;
    drw_d   = drw_q;
    grant_d = grant_q;
    ack_d   = {N_REQ{1'b0}};
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          owner_d = win_s;
          cnt_d   = 4'd1;
          data_d  = req_data[win_s*DATA_W +: DATA_W];
          de_d    = 1'b1;
          drw_d   = req_rw[win_s];
          grant_d = to_onehot(win_s);
          // With a single hold cycle the selecting edge is also the final bus edge.
          if (HOLD_LAST == 4'd1) begin
            ack_d   = to_onehot(win_s);
            ptr_d   = next_ptr(win_s);
            rdata_d = req_rw[win_s] ? rdata_q : bus_rdata;
            state_d = RELEASE;
          end else begin
            state_d = GRANT;
          end
        end else begin
          data_d  = {DATA_W{1'b0}};
          de_d    = 1'b0;
          drw_d   = 1'b0;
          grant_d = {N_REQ{1'b0}};
          rdata_d = {DATA_W{1'b0}};
          state_d = IDLE;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == HOLD_LAST) begin
          ack_d   = to_onehot(owner_q);
          ptr_d   = next_ptr(owner_q);
          rdata_d = drw_q ? rdata_q : bus_rdata;
          state_d = RELEASE;
        end else begin
          state_d = GRANT;
        end
      end
      RELEASE: begin
        cnt_d   = 4'd0;
        data_d  = {DATA_W{1'b0}};
        de_d    = 1'b0;
        grant_d = {N_REQ{1'b0}};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by resetn.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= {IDX_W{1'b0}};
      owner_q <= {IDX_W{1'b0}};
      cnt_q   <= 4'd0;
      data_q  <= {DATA_W{1'b0}};
      de_q    <= 1'b0;
      drw_q   <= 1'b0;
      grant_q <= {N_REQ{1'b0}};
      ack_q   <= {N_REQ{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      de_q    <= de_d;
      drw_q   <= drw_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign data  = data_q;
  assign DE    = de_q;
  assign DRW   = drw_q;
  assign grant = grant_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written corner
// sequences and random traffic, all compared against a transaction-timeline model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int H  = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rw;
  logic [DW-1:0]   bus_rdata;
  logic [DW-1:0]   data;
  logic            DE;
  logic            DRW;
  logic [N-1:0]    grant;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;

  bus_arbiter #(.N_REQ(N), .DATA_W(DW), .HOLD_CYCLES(H)) dut (
    .CLOCK_50(clk), .resetn(resetn), .req(req), .req_data(req_data),
    .req_rw(req_rw), .bus_rdata(bus_rdata), .data(data), .DE(DE), .DRW(DRW),
    .grant(grant), .ack(ack), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model: a transfer starting at edge t_start owns the bus for H edges, then one idle edge.
  int            ecount = 0;
  int            t_start = -1;
  int            m_ptr = 0;
  int            m_win = 0;
  logic [DW-1:0] m_wd;
  logic          m_rw;
  logic [DW-1:0] e_data, e_rdata;
  logic          e_de, e_drw;
  logic [N-1:0]  e_grant, e_ack;

  typedef struct {
    logic [N-1:0]  req;
    logic [DW-1:0] brd;
    logic [N-1:0]  g;
    logic          de;
    logic          drw;
    logic [DW-1:0] d;
    logic [N-1:0]  a;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t_start = -1;
    m_ptr   = 0;
    e_data  = '0; e_rdata = '0; e_de = 1'b0; e_drw = 1'b0;
    e_grant = '0; e_ack = '0;
  endtask

  task automatic model_edge();
    int rel;
    ecount++;
    e_ack = '0;
    if (t_start < 0) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (t_start < 0 && req[(m_ptr + k) % N]) begin
            m_win   = (m_ptr + k) % N;
            t_start = ecount;
          end
        end
        m_wd = req_data[m_win*DW +: DW];
        m_rw = req_rw[m_win];
      end else begin
        e_data = '0; e_de = 1'b0; e_drw = 1'b0; e_grant = '0; e_rdata = '0;
      end
    end
    if (t_start >= 0) begin
      rel = ecount - t_start;
      if (rel < H) begin
        e_de    = 1'b1;
        e_grant = {{(N-1){1'b0}}, 1'b1} << m_win;
        e_data  = m_wd;
        e_drw   = m_rw;
        if (rel == H-1) begin
          e_ack = e_grant;
          if (!m_rw) e_rdata = bus_rdata;
          m_ptr = (m_win + 1) % N;
        end
      end else begin
        e_de    = 1'b0;
        e_grant = '0;
        e_data  = '0;
        t_start = -1;
      end
    end
  endtask

  task automatic check_outputs();
    check("data", 32'(data), 32'(e_data));
    check("DE", 32'(DE), 32'(e_de));
    check("DRW", 32'(DRW), 32'(e_drw));
    check("grant", 32'(grant), 32'(e_grant));
    check("ack", 32'(ack), 32'(e_ack));
    if (e_ack != '0 || !resetn) check("rdata", 32'(rdata), 32'(e_rdata));
    check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
    check("ack_onehot0", 32'($countones(ack) <= 1), 32'd1);
  endtask

  task automatic tick();
    if (resetn) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    tbl[0] = '{req: 4'b0100, brd: 16'h0000, g: 4'b0100, de: 1'b1, drw: 1'b1, d: 16'h00A5, a: 4'b0000, rd: 16'h0000};
    tbl[1] = '{req: 4'b0100, brd: 16'h0000, g: 4'b0100, de: 1'b1, drw: 1'b1, d: 16'h00A5, a: 4'b0100, rd: 16'h0000};
    tbl[2] = '{req: 4'b0000, brd: 16'h0000, g: 4'b0000, de: 1'b0, drw: 1'b1, d: 16'h0000, a: 4'b0000, rd: 16'h0000};
    tbl[3] = '{req: 4'b0000, brd: 16'h0000, g: 4'b0000, de: 1'b0, drw: 1'b0, d: 16'h0000, a: 4'b0000, rd: 16'h0000};
    tbl[4] = '{req: 4'b1001, brd: 16'h0000, g: 4'b1000, de: 1'b1, drw: 1'b1, d: 16'h3333, a: 4'b0000, rd: 16'h0000};
    tbl[5] = '{req: 4'b1001, brd: 16'h0000, g: 4'b1000, de: 1'b1, drw: 1'b1, d: 16'h3333, a: 4'b1000, rd: 16'h0000};
    tbl[6] = '{req: 4'b0001, brd: 16'h0000, g: 4'b0000, de: 1'b0, drw: 1'b1, d: 16'h0000, a: 4'b0000, rd: 16'h0000};
    tbl[7] = '{req: 4'b0001, brd: 16'hBEEF, g: 4'b0001, de: 1'b1, drw: 1'b0, d: 16'h5A5A, a: 4'b0000, rd: 16'h0000};
    tbl[8] = '{req: 4'b0001, brd: 16'h1234, g: 4'b0001, de: 1'b1, drw: 1'b0, d: 16'h5A5A, a: 4'b0001, rd: 16'h1234};
    tbl[9] = '{req: 4'b0000, brd: 16'h0000, g: 4'b0000, de: 1'b0, drw: 1'b0, d: 16'h0000, a: 4'b0000, rd: 16'h0000};

    resetn    = 1'b0;
    req       = '0;
    req_data  = {16'h3333, 16'h00A5, 16'h7777, 16'h5A5A};
    req_rw    = 4'b1110;
    bus_rdata = '0;
    model_reset();
    #2;
    check_outputs();
    tick();
    tick();
    resetn = 1'b1;

    // Write by requester 2, ptr advance to 3, then a read by requester 0.
    for (int i = 0; i < 10; i++) begin
      req       = tbl[i].req;
      bus_rdata = tbl[i].brd;
      tick();
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("v%0d_DE", i), 32'(DE), 32'(tbl[i].de));
      check($sformatf("v%0d_DRW", i), 32'(DRW), 32'(tbl[i].drw));
      check($sformatf("v%0d_data", i), 32'(data), 32'(tbl[i].d));
      check($sformatf("v%0d_ack", i), 32'(ack), 32'(tbl[i].a));
      if (tbl[i].a != '0) check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
    end

    // Move ptr to 2, then req=0011 must serve requester 0 before 1.
    req = 4'b0010; tick(); tick(); req = 4'b0000; tick(); tick();
    req = 4'b0011; tick();
    check("ptr2_first", 32'(grant), 32'(4'b0001));
    tick(); tick(); tick();
    check("ptr2_second", 32'(grant), 32'(4'b0010));
    req = 4'b0000; tick(); tick(); tick();

    // Dropping req on the first bus cycle does not abort the transfer.
    req = 4'b0010; tick();
    req = 4'b0000; req_rw = 4'b0000; req_data = '0; tick();
    check("drop_ack", 32'(ack), 32'(4'b0010));
    check("drop_DRW", 32'(DRW), 32'(1'b1));
    tick(); tick();

    // Reset in the middle of a transfer clears outputs at once; no ack follows.
    req_data = {16'h3333, 16'h00A5, 16'h7777, 16'h5A5A};
    req = 4'b0100; tick();
    #2 resetn = 1'b0;
    #1 model_reset();
    check("rst_async_DE", 32'(DE), 32'd0);
    check("rst_async_grant", 32'(grant), 32'd0);
    check_outputs();
    tick();
    check("rst_no_ack", 32'(ack), 32'd0);
    resetn = 1'b1;
    req = 4'b1001; tick();
    check("rst_resume_grant", 32'(grant), 32'(4'b0001));
    req = 4'b0000; tick(); tick(); tick();

    // All four requesting from reset: strict rotation, one transfer every H+1 cycles.
    resetn = 1'b0; req = 4'b1111; tick();
    resetn = 1'b1;
    for (int i = 0; i < 13; i++) begin
      logic [N-1:0] exp_g;
      tick();
      if (i % 3 == 0) begin
        exp_g = {{(N-1){1'b0}}, 1'b1} << ((i / 3) % N);
        check($sformatf("rr_grant%0d", i / 3), 32'(grant), 32'(exp_g));
      end
    end
    req = 4'b0000; tick(); tick(); tick();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      req       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      req_data  = {$urandom, $urandom};
      req_rw    = 4'($urandom);
      bus_rdata = 16'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        resetn = 1'b0;
        #1 model_reset();
        check_outputs();
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
